// File: rtl/bank_arbiter.sv
// ---------------------------------------------------------------------------
// bank_arbiter
//
// Round-robin front end for a single data bank. Several requesters present
// read/write requests over a valid/ready handshake. One request per cycle is
// granted and turned into a registered bank command. Read results come back
// from the bank one cycle after the strobe and are steered to the port that
// issued them.
//
// Pipeline, with the handshake in cycle T:
//   T+1  S1: bank command registers plus read tag {valid, pid}
//   T+2  S2: tag waits while the bank drives bank_data_out
//   T+3  S3: rsp_valid (one-hot) / rsp_data registered
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   req_valid/req_we      per-port request valid and write flag
//   req_addr/req_wdata    per-port payload; port i at [i*REG_SIZE +: REG_SIZE]
//   req_ready             combinational grant, one-hot or zero
//   rsp_valid/rsp_data    read response, one-hot port qualifier, shared data
//   bank_addr/bank_data_in/bank_read_enable/bank_write_enable
//                         registered command to the bank
//   bank_data_out         bank read data, one cycle after the read strobe
// ---------------------------------------------------------------------------
module bank_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PID_W     = 2,
  parameter int REG_SIZE  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS-1:0]          req_we,
  input  logic [NUM_PORTS*REG_SIZE-1:0] req_addr,
  input  logic [NUM_PORTS*REG_SIZE-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]          req_ready,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  output logic [REG_SIZE-1:0]           rsp_data,
  output logic [REG_SIZE-1:0]           bank_addr,
  output logic [REG_SIZE-1:0]           bank_data_in,
  output logic                          bank_read_enable,
  output logic                          bank_write_enable,
  input  logic [REG_SIZE-1:0]           bank_data_out
);

  localparam logic [PID_W-1:0] LAST_ID = PID_W'(NUM_PORTS - 1);

  // Round-robin pointer: id of the most recently granted port.
  logic [PID_W-1:0] last_reg;

  logic [PID_W-1:0] cand;
  logic [PID_W-1:0] grant_id;
  logic             grant_found;
  logic             handshake;
  logic             grant_we;

  // Read tags travelling alongside the command.
  logic             s1_valid_reg;
  logic [PID_W-1:0] s1_pid_reg;
  logic             s2_valid_reg;
  logic [PID_W-1:0] s2_pid_reg;

  logic [REG_SIZE-1:0]  addr_arr  [NUM_PORTS];
  logic [REG_SIZE-1:0]  wdata_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0] pid_onehot;

  // Unpack the flat payload buses and build the response one-hot decoder.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign addr_arr[gi]   = req_addr[gi*REG_SIZE +: REG_SIZE];
      assign wdata_arr[gi]  = req_wdata[gi*REG_SIZE +: REG_SIZE];
      assign pid_onehot[gi] = (s2_pid_reg == PID_W'(gi));
    end
  endgenerate

  // Search last+1, last+2, ... with wrap. The candidate walks the ring one
  // step per iteration, so no modulo on a non-power-of-two count is needed.
  // The last iteration revisits last itself, so a lone requester that was
  // also the previous winner is still granted.
  always_comb begin
    cand        = last_reg;
    grant_id    = last_reg;
    grant_found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign handshake = grant_found && !reset;
  assign grant_we  = req_we[grant_id];

  always_comb begin
    req_ready = '0;
    if (handshake) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_reg          <= LAST_ID;
      bank_addr         <= '0;
      bank_data_in      <= '0;
      bank_read_enable  <= 1'b0;
      bank_write_enable <= 1'b0;
      s1_valid_reg      <= 1'b0;
      s1_pid_reg        <= '0;
      s2_valid_reg      <= 1'b0;
      s2_pid_reg        <= '0;
      rsp_valid         <= '0;
      rsp_data          <= '0;
    end else begin
      // S1: strobes are one-shot; address and data hold when idle.
      bank_read_enable  <= handshake && !grant_we;
      bank_write_enable <= handshake && grant_we;
      s1_valid_reg      <= handshake && !grant_we;
      s1_pid_reg        <= grant_id;
      if (handshake) begin
        last_reg     <= grant_id;
        bank_addr    <= addr_arr[grant_id];
        bank_data_in <= wdata_arr[grant_id];
      end

      // S2: tag lines up with bank_data_out.
      s2_valid_reg <= s1_valid_reg;
      s2_pid_reg   <= s1_pid_reg;

      // S3: capture the bank result and tag it with the issuing port.
      rsp_valid <= s2_valid_reg ? pid_onehot : '0;
      if (s2_valid_reg) begin
        rsp_data <= bank_data_out;
      end
    end
  end

endmodule

// File: tb/tb_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bank_arbiter
//
// Directed bench for bank_arbiter with four ports and 8-bit addresses/data.
// A small behavioural bank (one-cycle read latency, preload port) sits on
// the bank pins. Round-robin and wrap/skip behaviour are driven from a
// vector table; single read, write-then-read, reset mid-flight and idle are
// hand-written sequences. Inputs change on the falling edge and outputs are
// sampled 1 ns later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_bank_arbiter;

  localparam int NP = 4;
  localparam int RS = 8;

  logic            clk;
  logic            reset;
  logic [NP-1:0]   req_valid;
  logic [NP-1:0]   req_we;
  logic [NP*RS-1:0] req_addr;
  logic [NP*RS-1:0] req_wdata;
  logic [NP-1:0]   req_ready;
  logic [NP-1:0]   rsp_valid;
  logic [RS-1:0]   rsp_data;
  logic [RS-1:0]   bank_addr;
  logic [RS-1:0]   bank_data_in;
  logic            bank_read_enable;
  logic            bank_write_enable;
  logic [RS-1:0]   bank_data_out;

  logic [RS-1:0] addr_v  [NP];
  logic [RS-1:0] wdata_v [NP];

  // Bank model with preload port.
  logic          pl_en;
  logic [RS-1:0] pl_addr;
  logic [RS-1:0] pl_data;
  logic [RS-1:0] mem [256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NP-1:0] valid;
    logic [NP-1:0] exp_ready;
  } vec_t;

  localparam int NVEC = 12;
  vec_t tbl [NVEC];
  logic [NP-1:0] exp_gnt [NVEC+4];

  bank_arbiter #(.NUM_PORTS(NP), .PID_W(2), .REG_SIZE(RS)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_we            (req_we),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .bank_addr         (bank_addr),
    .bank_data_in      (bank_data_in),
    .bank_read_enable  (bank_read_enable),
    .bank_write_enable (bank_write_enable),
    .bank_data_out     (bank_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NP; i++) begin
      req_addr[i*RS +: RS]  = addr_v[i];
      req_wdata[i*RS +: RS] = wdata_v[i];
    end
  end

  always_ff @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bank_write_enable) begin
      mem[bank_addr] <= bank_data_in;
    end
    if (bank_read_enable) begin
      bank_data_out <= mem[bank_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [RS-1:0] a, input logic [RS-1:0] d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // Returns on a falling edge with reset just released; caller drives the
  // first post-reset cycle from there.
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [RS-1:0] pid_data(input logic [NP-1:0] oh);
    logic [RS-1:0] d;
    d = 8'hC0;
    for (int p = 0; p < NP; p++) begin
      if (oh[p]) d = 8'hC0 + RS'(p);
    end
    return d;
  endfunction

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    pl_en     = 1'b0;
    pl_addr   = '0;
    pl_data   = '0;
    for (int p = 0; p < NP; p++) begin
      addr_v[p]  = '0;
      wdata_v[p] = 8'h70 + RS'(p);
    end

    // Bank contents used by the read tests.
    preload(8'h10, 8'h5A);
    for (int p = 0; p < NP; p++) begin
      preload(8'h20 + RS'(p), 8'hC0 + RS'(p));
    end

    // ---- Reset state: grants suppressed even with requests pending.
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_bank_re", 32'(bank_read_enable), 32'h0);
    chk("reset_bank_we", 32'(bank_write_enable), 32'h0);
    chk("reset_bank_addr", 32'(bank_addr), 32'h0);
    chk("reset_bank_din", 32'(bank_data_in), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_data", 32'(rsp_data), 32'h0);

    // ---- Single read: port 2 reads 0x10 (holds 0x5A).
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 4'b0100;
    req_we    = '0;
    addr_v[2] = 8'h10;
    #1 chk("rd_ready_T", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rd_re_T1", 32'(bank_read_enable), 32'h1);
    chk("rd_we_T1", 32'(bank_write_enable), 32'h0);
    chk("rd_addr_T1", 32'(bank_addr), 32'h10);
    chk("rd_rsp_T1", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    #1 chk("rd_rsp_T2", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    #1;
    chk("rd_rsp_valid_T3", 32'(rsp_valid), 32'h4);
    chk("rd_rsp_data_T3", 32'(rsp_data), 32'h5A);
    @(negedge clk);
    #1 chk("rd_rsp_T4", 32'(rsp_valid), 32'h0);
    $display("single read: port 2 addr 10 data %0h", rsp_data);

    // ---- Write then read: port 0 writes 0x33 to 0x04, then reads it.
    @(negedge clk);
    req_valid  = 4'b0001;
    req_we     = 4'b0001;
    addr_v[0]  = 8'h04;
    wdata_v[0] = 8'h33;
    #1 chk("wr_ready_T", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_we = '0;
    #1;
    chk("wr_ready_T1", 32'(req_ready), 32'h1);
    chk("wr_we_T1", 32'(bank_write_enable), 32'h1);
    chk("wr_re_T1", 32'(bank_read_enable), 32'h0);
    chk("wr_addr_T1", 32'(bank_addr), 32'h04);
    chk("wr_din_T1", 32'(bank_data_in), 32'h33);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("wr_re_T2", 32'(bank_read_enable), 32'h1);
    chk("wr_we_T2", 32'(bank_write_enable), 32'h0);
    chk("wr_addr_T2", 32'(bank_addr), 32'h04);
    @(negedge clk);
    #1 chk("wr_rsp_T3", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    #1;
    chk("wr_rsp_valid_T4", 32'(rsp_valid), 32'h1);
    chk("wr_rsp_data_T4", 32'(rsp_data), 32'h33);
    $display("write then read: port 0 addr 04 data %0h", rsp_data);

    // ---- Table: round robin from reset, then wrap and skip.
    tbl[0]  = '{4'hF, 4'h1};
    tbl[1]  = '{4'hF, 4'h2};
    tbl[2]  = '{4'hF, 4'h4};
    tbl[3]  = '{4'hF, 4'h8};
    tbl[4]  = '{4'hF, 4'h1};
    tbl[5]  = '{4'hF, 4'h2};
    tbl[6]  = '{4'h4, 4'h4};  // last becomes 2
    tbl[7]  = '{4'hA, 4'h8};  // ports 1,3 valid: 3 first
    tbl[8]  = '{4'hA, 4'h2};  // then 1 after wrap
    tbl[9]  = '{4'h0, 4'h0};
    tbl[10] = '{4'h9, 4'h8};  // last=1: 3 beats 0
    tbl[11] = '{4'h9, 4'h1};
    for (int i = 0; i < NVEC + 4; i++) begin
      exp_gnt[i] = (i < NVEC) ? tbl[i].exp_ready : '0;
    end
    for (int p = 0; p < NP; p++) begin
      addr_v[p] = 8'h20 + RS'(p);
    end
    req_we = '0;
    do_reset();
    for (int i = 0; i < NVEC + 4; i++) begin
      if (i > 0) @(negedge clk);
      req_valid = (i < NVEC) ? tbl[i].valid : '0;
      #1;
      chk($sformatf("tbl_ready[%0d]", i), 32'(req_ready), 32'(exp_gnt[i]));
      chk($sformatf("tbl_re[%0d]", i), 32'(bank_read_enable),
          (i >= 1 && exp_gnt[i-1] != '0) ? 32'h1 : 32'h0);
      chk($sformatf("tbl_rsp[%0d]", i), 32'(rsp_valid),
          (i >= 3) ? 32'(exp_gnt[i-3]) : 32'h0);
      if (i >= 3 && exp_gnt[i-3] != '0) begin
        chk($sformatf("tbl_rdata[%0d]", i), 32'(rsp_data), 32'(pid_data(exp_gnt[i-3])));
      end
      $display("vec %0d: valid %b ready %b rsp_valid %b rsp_data %0h",
               i, req_valid, req_ready, rsp_valid, rsp_data);
    end

    // ---- Reset mid-flight: reads from ports 0 and 1 are discarded.
    do_reset();
    req_valid = 4'b0011;
    #1 chk("rst_ready_T", 32'(req_ready), 32'h1);
    @(negedge clk);
    #1 chk("rst_ready_T1", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    reset     = 1'b1;
    #1 chk("rst_ready_T2", 32'(req_ready), 32'h0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 4'b0011;
    #1;
    chk("rst_bank_addr", 32'(bank_addr), 32'h0);
    chk("rst_bank_din", 32'(bank_data_in), 32'h0);
    chk("rst_bank_re", 32'(bank_read_enable), 32'h0);
    chk("rst_bank_we", 32'(bank_write_enable), 32'h0);
    chk("rst_rsp_T3", 32'(rsp_valid), 32'h0);
    chk("rst_ready_after", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    #1 chk("rst_rsp_T4", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    #1 chk("rst_rsp_T5", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    #1;
    chk("rst_rsp_T6", 32'(rsp_valid), 32'h1);
    chk("rst_rdata_T6", 32'(rsp_data), 32'hC0);
    $display("reset mid-flight: post-reset read port 0 data %0h", rsp_data);

    // ---- Idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      chk($sformatf("idle_ready[%0d]", i), 32'(req_ready), 32'h0);
      chk($sformatf("idle_re[%0d]", i), 32'(bank_read_enable), 32'h0);
      chk($sformatf("idle_we[%0d]", i), 32'(bank_write_enable), 32'h0);
      chk($sformatf("idle_rsp[%0d]", i), 32'(rsp_valid), 32'h0);
    end
    $display("idle: 10 cycles");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_arbiter.md
# bank_arbiter

Round-robin front end for one data bank. It accepts read/write requests from `NUM_PORTS` requesters, such as GPU cores or a loader, over a valid/ready handshake. It issues at most one registered command per cycle to a single `bank` instance and routes each read result back to the requester that issued it. It sits between the core request buses and the bank's `addr`/`data_in`/`read_enable`/`write_enable`/`data_out` pins.

## Interface
- `NUM_PORTS`, default 4: number of requesters, from 2 to 8.
- `PID_W`, default 2: port-id width, equal to ceil(log2(`NUM_PORTS`)).
- `clk` in, 1 bit: single clock, rising edge.
- `reset` in, 1 bit: synchronous, active-high.
- `req_valid` in, `NUM_PORTS` bits: bit i means port i has a request pending.
- `req_we` in, `NUM_PORTS` bits: bit i set is a write, clear is a read.
- `req_addr` in, `NUM_PORTS`*`REG_SIZE` bits: port i occupies slice [i*`REG_SIZE` +: `REG_SIZE`].
- `req_wdata` in, `NUM_PORTS`*`REG_SIZE` bits: write data, sliced the same way as `req_addr`.
- `req_ready` out, `NUM_PORTS` bits: grant, one-hot or zero.
- `rsp_valid` out, `NUM_PORTS` bits: read data is valid for port i.
- `rsp_data` out, `REG_SIZE` bits: read data, shared by all ports and qualified by `rsp_valid`.
- `bank_addr` out, `REG_SIZE` bits: registered bank address.
- `bank_data_in` out, `REG_SIZE` bits: registered write data.
- `bank_read_enable` out, 1 bit: registered read strobe.
- `bank_write_enable` out, 1 bit: registered write strobe.
- `bank_data_out` in, `REG_SIZE` bits: bank read data, valid one cycle after the read strobe is sampled.

## Operation
- **Arbitration.**
  - Round robin with pointer `last`, the id of the last granted port.
  - Search order is `last`+1, `last`+2, …, wrapping modulo `NUM_PORTS`.
  - The first port with `req_valid` high gets `req_ready` high in the same cycle. `req_ready` is combinational from `req_valid` and `last`.
  - A handshake (`req_valid` & `req_ready`) updates `last` to the granted id.
  - `req_ready` is never high for a port whose `req_valid` is low.
  - `req_ready` is all-zero while `reset` is high.
- **Command stage (S1).**
  - On a handshake, the bank outputs are registered from the granted port's slice:
    - `bank_addr` from that port's address;
    - `bank_data_in` from that port's write data;
    - `bank_write_enable` = `req_we`;
    - `bank_read_enable` = ~`req_we`.
  - With no handshake, both strobes register 0. `bank_addr` and `bank_data_in` hold their previous values.
  - For a read, a tag {valid, pid} is registered alongside the command.
- **Bank stage (S2).**
  - The tag advances one register, matching the bank's one-cycle read latency.
- **Response stage (S3).**
  - If the S2 tag is valid: `rsp_data` <= `bank_data_out`, and `rsp_valid` <= one-hot(pid). Otherwise `rsp_valid` <= 0, and `rsp_data` holds.
- **Write responses.** Writes produce no response.
- **Ordering.**
  - Commands reach the bank in grant order.
  - A read granted after a write to the same address returns the new data.
- **No response backpressure.** Requesters must accept `rsp_valid` in the cycle it is asserted.
- **Simultaneous requests.** Exactly one port is granted per cycle. Ungranted ports keep `req_valid` and their payload stable until granted.

## Timing
- **Throughput.** One command per cycle. The pipeline never stalls.
- **Read latency.**
  - Handshake in cycle T.
  - Bank command visible during T+1; the bank samples it at the end of T+1.
  - `bank_data_out` is valid during T+2.
  - `rsp_valid`/`rsp_data` are visible during T+3.
- **Write latency.** The bank memory is updated at the end of T+1.
- **Reset values**, taking effect at the first edge where `reset` is high:
  - all `bank_*` outputs 0;
  - tags invalid;
  - `rsp_valid` 0 and `rsp_data` 0;
  - `last` = `NUM_PORTS`-1, so port 0 has first priority.
- **Reset mid-operation.** In-flight reads are discarded and no `rsp_valid` is emitted for them. Write strobes are forced low, so no spurious bank write occurs.
- **First cycle after reset deasserts.** Arbitration resumes with port 0 first.

## Test plan
- **Single read.** Port 2 reads addr 0x10, where the bank holds 0x5A, with handshake at T -> `bank_read_enable`=1 and `bank_addr`=0x10 during T+1; `rsp_valid`=4'b0100 and `rsp_data`=0x5A during T+3; no other `rsp_valid` bits set.
- **Write then read.** Port 0 writes 0x33 to addr 0x04, then reads addr 0x04 on the next cycle -> write strobe at T+1, read strobe at T+2, response 0x33 at T+4.
- **Round robin.** All four ports hold `req_valid` continuously from reset -> grant sequence 0,1,2,3,0,1; each `req_ready` is one-hot; back-to-back responses are tagged with the matching port.
- **Wrap and skip.** With `last`=2, only ports 1 and 3 valid -> port 3 granted first, then port 1 after wrap-around.
- **Reset mid-flight.** Issue reads from ports 0 and 1, then assert `reset` for 1 cycle at T+1 -> no `rsp_valid` for either read; all `bank_*` outputs read 0 the cycle after; the next grant goes to port 0.
- **Idle.** No `req_valid` for 10 cycles -> `req_ready`=0, both bank strobes 0, `rsp_valid`=0 throughout.
